// File: rtl/syzyf_code_pkg.sv
// Shared geometry, status and FSM encodings for the 128-bit table-parity code.
package syzyf_code_pkg;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;

  // Bit offsets of the parity bytes within the 64-bit check field
  localparam int unsigned ROW_OFS  = 56;
  localparam int unsigned COL_OFS  = 48;
  localparam int unsigned DIAG_OFS = 40;
  localparam int unsigned ANTI_OFS = 32;

  localparam logic [1:0] ST_CLEAN     = 2'd0;
  localparam logic [1:0] ST_DATA_FIX  = 2'd1;
  localparam logic [1:0] ST_CHECK_FIX = 2'd2;
  localparam logic [1:0] ST_UNCORR    = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StEval,
    StHold
  } dec_state_e;

  // Position of the highest set bit; only meaningful for one-hot input
  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/decoder_syndrome_eval.sv
// Classifies the 32 syndrome bits plus the reserved field into a status and error location.
module decoder_syndrome_eval
  import syzyf_code_pkg::*;
(
  input  logic [7:0]  s_row,
  input  logic [7:0]  s_col,
  input  logic [7:0]  s_diag,
  input  logic [7:0]  s_anti,
  input  logic [31:0] reserved,
  output logic [1:0]  cls,
  output logic [2:0]  err_r,
  output logic [2:0]  err_c
);

  logic [2:0] r_idx;
  logic [2:0] c_idx;
  logic [2:0] d_idx;
  logic [2:0] a_idx;
  logic       all_zero;
  logic       single_data;

  // Decode candidate location and test it against the diagonal and anti-diagonal
  always_comb begin
    r_idx       = onehot_idx(s_row);
    c_idx       = onehot_idx(s_col);
    d_idx       = c_idx - r_idx;
    a_idx       = c_idx + r_idx;
    all_zero    = ({s_row, s_col, s_diag, s_anti, reserved} == 64'd0);
    single_data = $onehot(s_row) && $onehot(s_col) &&
                  (s_diag == (8'd1 << d_idx)) && (s_anti == (8'd1 << a_idx)) &&
                  (reserved == 32'd0);
    cls   = ST_UNCORR;
    err_r = 3'd0;
    err_c = 3'd0;
    if (all_zero) begin
      cls = ST_CLEAN;
    end else if (single_data) begin
      cls   = ST_DATA_FIX;
      err_r = r_idx;
      err_c = c_idx;
    end else if ($onehot({s_row, s_col, s_diag, s_anti, reserved})) begin
      cls = ST_CHECK_FIX;
    end
  end

endmodule

// File: rtl/decoder.sv
// Row-serial table-parity decoder: accumulates parities over 8 cycles, then corrects and reports.
module decoder
  import syzyf_code_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] codeword,
  input  logic         debug_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  data_out,
  output logic [1:0]   status,
  output logic [2:0]   err_row,
  output logic [2:0]   err_col
);

  dec_state_e   state;
  logic [2:0]   cnt;
  logic [127:0] cw;
  logic [7:0]   acc_row;
  logic [7:0]   acc_col;
  logic [7:0]   acc_diag;
  logic [7:0]   acc_anti;

  logic [7:0]   row_bits;
  logic [7:0]   diag_rot;
  logic [7:0]   anti_rot;
  logic [1:0]   cls;
  logic [2:0]   fix_r;
  logic [2:0]   fix_c;

  // debug_mode never influences the datapath
  logic unused_debug;
  assign unused_debug = debug_mode;

  assign in_ready = rst_n && (state == StIdle);

  // Current row, remapped so bit i lands on diagonal / anti-diagonal index i
  always_comb begin
    row_bits = cw[64 + {cnt, 3'b000} +: COLS];
    for (int unsigned i = 0; i < 8; i++) begin
      diag_rot[i] = row_bits[3'(i) + cnt];
      anti_rot[i] = row_bits[3'(i) - cnt];
    end
  end

  decoder_syndrome_eval u_eval (
    .s_row    (acc_row  ^ cw[ROW_OFS  +: 8]),
    .s_col    (acc_col  ^ cw[COL_OFS  +: 8]),
    .s_diag   (acc_diag ^ cw[DIAG_OFS +: 8]),
    .s_anti   (acc_anti ^ cw[ANTI_OFS +: 8]),
    .reserved (cw[31:0]),
    .cls      (cls),
    .err_r    (fix_r),
    .err_c    (fix_c)
  );

  // Control FSM with registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cnt       <= 3'd0;
      cw        <= 128'd0;
      acc_row   <= 8'd0;
      acc_col   <= 8'd0;
      acc_diag  <= 8'd0;
      acc_anti  <= 8'd0;
      out_valid <= 1'b0;
      data_out  <= 64'd0;
      status    <= ST_CLEAN;
      err_row   <= 3'd0;
      err_col   <= 3'd0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            cw       <= codeword;
            cnt      <= 3'd0;
            acc_row  <= 8'd0;
            acc_col  <= 8'd0;
            acc_diag <= 8'd0;
            acc_anti <= 8'd0;
            state    <= StAccum;
          end
        end
        StAccum: begin
          acc_row[cnt] <= ^row_bits;
          acc_col      <= acc_col ^ row_bits;
          acc_diag     <= acc_diag ^ diag_rot;
          acc_anti     <= acc_anti ^ anti_rot;
          cnt          <= cnt + 3'd1;
          if (cnt == 3'(ROWS - 1)) state <= StEval;
        end
        StEval: begin
          status    <= cls;
          err_row   <= fix_r;
          err_col   <= fix_c;
          data_out  <= (cls == ST_DATA_FIX) ? (cw[127:64] ^ (64'd1 << {fix_r, fix_c}))
                                            : cw[127:64];
          out_valid <= 1'b1;
          state     <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for the table-parity decoder.
module tb_decoder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] codeword = '0;
  logic         debug_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  data_out;
  logic [1:0]   status;
  logic [2:0]   err_row;
  logic [2:0]   err_col;

  int n_checks = 0;
  int n_pass = 0;

  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;

  always #5 clk = ~clk;

  decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .codeword   (codeword),
    .debug_mode (debug_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .status     (status),
    .err_row    (err_row),
    .err_col    (err_col)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference encoder producing the codeword for a data word
  function automatic logic [127:0] enc(input logic [63:0] d);
    logic [7:0] pr, pc, pd, pa;
    pr = '0; pc = '0; pd = '0; pa = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        pr[r]               ^= d[r*8+c];
        pc[c]               ^= d[r*8+c];
        pd[(c - r + 8) % 8] ^= d[r*8+c];
        pa[(c + r) % 8]     ^= d[r*8+c];
      end
    end
    return {d, pr, pc, pd, pa, 32'h0};
  endfunction

  function automatic logic [127:0] flip(input logic [127:0] cw, input int bit_idx);
    logic [127:0] m;
    m = 128'd1 << bit_idx;
    return cw ^ m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one codeword and wait for out_valid; returns edges from accept to result
  task automatic send(input logic [127:0] cw, output int lat);
    codeword = cw;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_case(input string tag, input logic [127:0] cw, input logic [63:0] exp_d,
                          input logic [1:0] exp_st, input logic [2:0] exp_r,
                          input logic [2:0] exp_c);
    int lat;
    check({tag, "_ready"}, 128'(in_ready), 128'd1);
    send(cw, lat);
    check({tag, "_lat"}, 128'(lat), 128'd9);
    check({tag, "_data"}, 128'(data_out), 128'(exp_d));
    check({tag, "_status"}, 128'(status), 128'(exp_st));
    check({tag, "_row"}, 128'(err_row), 128'(exp_r));
    check({tag, "_col"}, 128'(err_col), 128'(exp_c));
    release_out();
  endtask

  initial begin
    int lat;
    logic [127:0] c0;
    c0 = enc(D0);

    // Reset state
    #2;
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_data", 128'(data_out), 128'd0);
    check("rst_status", 128'(status), 128'd0);
    check("rst_err", 128'({err_row, err_col}), 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready", 128'(in_ready), 128'd1);

    run_case("clean", c0, D0, 2'd0, 3'd0, 3'd0);
    run_case("dfix52", flip(c0, 64 + 42), D0, 2'd1, 3'd5, 3'd2);
    run_case("cfix50", flip(c0, 50), D0, 2'd2, 3'd0, 3'd0);
    run_case("rsv7", flip(c0, 7), D0, 2'd2, 3'd0, 3'd0);
    run_case("dbl", flip(flip(c0, 64 + 9), 64 + 51), 64'h012B_4567_89AB_CFEF, 2'd3, 3'd0, 3'd0);

    // Back-pressure: hold result 20 cycles while the next codeword waits
    send(c0, lat);
    check("bp_lat", 128'(lat), 128'd9);
    codeword = flip(c0, 64 + 56);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_hold", 128'({out_valid, in_ready, status, data_out}), 128'({2'b10, 2'd0, D0}));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_idle_valid", 128'(out_valid), 128'd0);
    check("hs_idle_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    check("hs_accepted", 128'(in_ready), 128'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("b2b_lat", 128'(lat), 128'd9);
    check("b2b_data", 128'(data_out), 128'(D0));
    check("b2b_status", 128'(status), 128'd1);
    check("b2b_loc", 128'({err_row, err_col}), 128'({3'd7, 3'd0}));
    release_out();

    // Reset in the middle of accumulation
    codeword = enc(D1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_valid), 128'd0);
    check("mid_rst_data", 128'(data_out), 128'd0);
    check("mid_rst_status", 128'(status), 128'd0);
    check("mid_rst_err", 128'({err_row, err_col}), 128'd0);
    check("mid_rst_ready", 128'(in_ready), 128'd0);
    tick();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("no_partial", 128'({out_valid, in_ready}), 128'b01);
    end
    run_case("fresh", flip(enc(D1), 64 + 30), D1, 2'd1, 3'd3, 3'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
